// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier control block and its datapath.
package mult_pkg;

    localparam int WIDTH  = 16;
    localparam int STEP_W = 5;

    // Index of the final RUN cycle; a 16-bit multiplier never needs more than 16 steps.
    localparam logic [STEP_W-1:0] LAST_STEP = 5'd15;
    localparam logic [STEP_W-1:0] STEP_ONE  = 5'd1;
    localparam logic [STEP_W-1:0] STEP_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : mult_pkg

// File: rtl/shift_right_register.sv
// Loadable logical right-shift register holding the remaining multiplier bits.
module shift_right_register
    import mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Load wins over shift; a zero enters at the MSB on every shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {WIDTH{1'b0}};
        end else if (load) begin
            r_q <= d;
        end else if (shift_en) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end else begin
            r_q <= r_q;
        end
    end

    assign q = r_q;

endmodule : shift_right_register

// File: rtl/multiplier_shift_right_unit.sv
// Control unit for a shift-and-add multiplier: walks the multiplier bits LSB first,
// asserting add_en for each set bit while an external multiplicand register shifts left.
module multiplier_shift_right_unit
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  multiplier,
    output logic              load,
    output logic              add_en,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  q,
    output logic [STEP_W-1:0] step
);

    state_t              r_state;
    state_t              w_next_state;
    logic [STEP_W-1:0]   r_step;
    logic [WIDTH-1:0]    w_q;
    logic                w_sr_load;
    logic                w_shift_en;
    logic                w_run_last;

    // Operands are captured on the accepting edge so LOAD already sees the multiplier.
    assign w_sr_load  = (r_state == IDLE) && start;
    assign w_shift_en = (r_state == RUN);
    // Stop after step 15, or as soon as no set bits remain above the current one.
    assign w_run_last = (r_step == LAST_STEP) || (w_q[WIDTH-1:1] == {(WIDTH-1){1'b0}});

    shift_right_register u_shift_right_register (
        .clk      (clk),
        .rst      (rst),
        .load     (w_sr_load),
        .shift_en (w_shift_en),
        .d        (multiplier),
        .q        (w_q)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so requests are never queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                w_next_state = RUN;
            end
            RUN: begin
                if (w_run_last) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = RUN;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Step counter: cleared when an operation is accepted, advanced on every RUN edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step <= STEP_ZERO;
        end else if (w_sr_load) begin
            r_step <= STEP_ZERO;
        end else if (r_state == RUN) begin
            r_step <= r_step + STEP_ONE;
        end else begin
            r_step <= r_step;
        end
    end

    // Strobes decode only from the state register and q[0], never from start/multiplier.
    always_comb begin
        load   = 1'b0;
        add_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
            end
            LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            RUN: begin
                add_en = w_q[0];
                busy   = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign q    = w_q;
    assign step = r_step;

endmodule : multiplier_shift_right_unit

// File: tb/tb_multiplier_shift_right_unit.sv
// Directed self-checking bench for multiplier_shift_right_unit.
module tb_multiplier_shift_right_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] multiplier;
    logic        load;
    logic        add_en;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [4:0]  step;

    int total;
    int bad;

    multiplier_shift_right_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .multiplier (multiplier),
        .load       (load),
        .add_en     (add_en),
        .busy       (busy),
        .done       (done),
        .q          (q),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        multiplier = 16'h0000;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (load !== 1'b0) begin bad++; $display("FAIL reset_load got=%b want=0", load); end
        total++; if (add_en !== 1'b0) begin bad++; $display("FAIL reset_add_en got=%b want=0", add_en); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL reset_q got=%h want=0000", q); end
        total++; if (step !== 5'd0) begin bad++; $display("FAIL reset_step got=%0d want=0", step); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", busy); end
    endtask

    // One complete operation; n is the hand-derived RUN length for m.
    task automatic test_single_op(input string tag, input logic [15:0] m, input int n);
        logic [15:0] exp_q;
        start = 1'b1;
        multiplier = m;
        tick();
        start = 1'b0;
        multiplier = 16'hDEAD;
        total++; if (load !== 1'b1) begin bad++; $display("FAIL %s load_state_load got=%b want=1", tag, load); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s load_state_busy got=%b want=1", tag, busy); end
        total++; if (add_en !== 1'b0) begin bad++; $display("FAIL %s load_state_add_en got=%b want=0", tag, add_en); end
        total++; if (q !== m) begin bad++; $display("FAIL %s load_state_q got=%h want=%h", tag, q, m); end
        total++; if (step !== 5'd0) begin bad++; $display("FAIL %s load_state_step got=%0d want=0", tag, step); end
        tick();
        for (int k = 0; k < n; k++) begin
            exp_q = m >> k;
            // A request during RUN must be ignored.
            start = 1'b1;
            multiplier = 16'h1234;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s run%0d_busy got=%b want=1", tag, k, busy); end
            total++; if (load !== 1'b0) begin bad++; $display("FAIL %s run%0d_load got=%b want=0", tag, k, load); end
            total++; if (done !== 1'b0) begin bad++; $display("FAIL %s run%0d_done got=%b want=0", tag, k, done); end
            total++; if (step !== k[4:0]) begin bad++; $display("FAIL %s run%0d_step got=%0d want=%0d", tag, k, step, k); end
            total++; if (q !== exp_q) begin bad++; $display("FAIL %s run%0d_q got=%h want=%h", tag, k, q, exp_q); end
            total++; if (add_en !== exp_q[0]) begin bad++; $display("FAIL %s run%0d_add_en got=%b want=%b", tag, k, add_en, exp_q[0]); end
            tick();
        end
        start = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done_pulse got=%b want=1", tag, done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s done_busy got=%b want=0", tag, busy); end
        total++; if (add_en !== 1'b0) begin bad++; $display("FAIL %s done_add_en got=%b want=0", tag, add_en); end
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL %s done_q got=%h want=0000", tag, q); end
        if (n < 16) begin
            total++; if (step !== n[4:0]) begin bad++; $display("FAIL %s done_step got=%0d want=%0d", tag, step, n); end
        end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s idle_done got=%b want=0", tag, done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s idle_busy got=%b want=0", tag, busy); end
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s idle_hold_busy got=%b want=0", tag, busy); end
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL %s idle_hold_q got=%h want=0000", tag, q); end
        if (n < 16) begin
            total++; if (step !== n[4:0]) begin bad++; $display("FAIL %s idle_hold_step got=%0d want=%0d", tag, step, n); end
        end
    endtask

    task automatic test_reset_abort();
        start = 1'b1;
        multiplier = 16'h00A5;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        total++; if (step !== 5'd3) begin bad++; $display("FAIL abort_pre_step got=%0d want=3", step); end
        total++; if (q !== 16'h0014) begin bad++; $display("FAIL abort_pre_q got=%h want=0014", q); end
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (add_en !== 1'b0) begin bad++; $display("FAIL abort_add_en got=%b want=0", add_en); end
        total++; if (q !== 16'h0000) begin bad++; $display("FAIL abort_q got=%h want=0000", q); end
        total++; if (step !== 5'd0) begin bad++; $display("FAIL abort_step got=%0d want=0", step); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_in_reset_done%0d got=%b want=0", i, done); end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_after_done%0d got=%b want=0", i, done); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_after_busy%0d got=%b want=0", i, busy); end
        end
        test_single_op("after_abort_0003", 16'h0003, 2);
    endtask

    // start held high: LOAD, RUN, RUN, DONE, IDLE repeating with period 5.
    task automatic test_back_to_back();
        logic       exp_load;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_add;
        logic [4:0] exp_step;
        start = 1'b1;
        multiplier = 16'h0002;
        for (int i = 0; i < 15; i++) begin
            tick();
            exp_load = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_add  = 1'b0;
            exp_step = 5'd2;
            case (i % 5)
                0: begin exp_load = 1'b1; exp_busy = 1'b1; exp_step = 5'd0; end
                1: begin exp_busy = 1'b1; exp_step = 5'd0; end
                2: begin exp_busy = 1'b1; exp_add = 1'b1; exp_step = 5'd1; end
                3: begin exp_done = 1'b1; end
                default: begin exp_busy = 1'b0; end
            endcase
            total++; if (load !== exp_load) begin bad++; $display("FAIL b2b_c%0d_load got=%b want=%b", i, load, exp_load); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL b2b_c%0d_busy got=%b want=%b", i, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL b2b_c%0d_done got=%b want=%b", i, done, exp_done); end
            total++; if (add_en !== exp_add) begin bad++; $display("FAIL b2b_c%0d_add_en got=%b want=%b", i, add_en, exp_add); end
            total++; if (step !== exp_step) begin bad++; $display("FAIL b2b_c%0d_step got=%0d want=%0d", i, step, exp_step); end
        end
        start = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy got=%b want=0", busy); end
        total++; if (load !== 1'b0) begin bad++; $display("FAIL b2b_stop_load got=%b want=0", load); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_op("m0001", 16'h0001, 1);
        test_single_op("m8000", 16'h8000, 16);
        test_single_op("mFFFF", 16'hFFFF, 16);
        test_single_op("m0000", 16'h0000, 1);
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_multiplier_shift_right_unit
